demux_frame_router: RTL and testbench



---
 rtl/demux_frame_router_pkg.sv | 19 +
 rtl/demux_frame_router_if.sv | 30 +++
 rtl/demux_frame_router_frame_counter_bank.sv | 41 ++++
 rtl/demux_frame_router.sv | 182 ++++++++++++++++++
 tb/tb_demux_frame_router.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_frame_router_pkg.sv
// -----------------------------------------------------------------------------
// demux_frame_router_pkg
// Shared types and constants for the demux frame router: the parser FSM state
// encoding, the frame header width and the number of demux channels.
// -----------------------------------------------------------------------------
package demux_frame_router_pkg;

   // Frame parser states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // waiting for header MSB
      HDR     = 2'd1,   // waiting for header LSB
      PAYLOAD = 2'd2,   // forwarding payload bits to the demux
      DROP    = 2'd3    // swallowing payload of a disabled channel
   } state_e;

   localparam int HDR_W = 2;   // channel header bits per frame
   localparam int N_CH  = 4;   // demux output channels

endpackage : demux_frame_router_pkg

// File: rtl/demux_frame_router_if.sv
// -----------------------------------------------------------------------------
// demux_frame_router_if
// Serial bit-stream handshake between the upstream source and the router.
//   s_valid : upstream bit valid            (master -> slave)
//   s_data  : upstream serial bit           (master -> slave)
//   hold    : downstream stall request      (master -> slave)
//   s_ready : router can accept a bit       (slave  -> master)
// -----------------------------------------------------------------------------
interface demux_frame_router_if;

   logic s_valid;
   logic s_data;
   logic hold;
   logic s_ready;

   modport master (
      output s_valid,
      output s_data,
      output hold,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  hold,
      output s_ready
   );

endinterface : demux_frame_router_if

// File: rtl/demux_frame_router_frame_counter_bank.sv
// -----------------------------------------------------------------------------
// frame_counter_bank
// One CNT_W-bit frame counter per demux channel. Counters wrap modulo 2^CNT_W.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc_i        : increment strobe for counter[inc_ch_i]
//   inc_ch_i     : channel to increment
//   rd_sel_i     : read address
//   rd_data_o    : combinational read of counter[rd_sel_i]; shows the value
//                  before any increment happening in the same cycle
// -----------------------------------------------------------------------------
module frame_counter_bank
   import demux_frame_router_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   input  logic [1:0]       inc_ch_i,
   input  logic [1:0]       rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o
);

   logic [CNT_W-1:0] cnt_q [N_CH];

   // Per-channel frame counters
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < N_CH; k++) begin
            cnt_q[k] <= {CNT_W{1'b0}};
         end
      end else if (inc_i) begin
         cnt_q[inc_ch_i] <= cnt_q[inc_ch_i] + CNT_W'(1);
      end else begin
         cnt_q[inc_ch_i] <= cnt_q[inc_ch_i];
      end
   end

   assign rd_data_o = cnt_q[rd_sel_i];

endmodule : frame_counter_bank

// File: rtl/demux_frame_router.sv
// -----------------------------------------------------------------------------
// demux_frame_router
// Parses a serial bit stream into frames (2-bit channel header followed by
// PAYLOAD_LEN payload bits) and feeds them to a 1-to-4 demux.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   s_if         : upstream bit handshake (s_valid/s_data/hold in, s_ready out)
//   chan_en      : per-channel enable, sampled when the header completes
//   dmx_select   : demux select, updated only when an enabled header completes
//   dmx_data     : payload bit, 0 outside payload transfers
//   dmx_valid    : dmx_data carries a payload bit
//   frame_done   : pulse with the last payload bit of a delivered frame
//   frame_drop   : pulse when a disabled channel's frame has been consumed
//   busy         : parser not in IDLE
//   cnt_rd_sel   : frame counter read address
//   cnt_rd_data  : combinational frame counter read
// -----------------------------------------------------------------------------
module demux_frame_router
   import demux_frame_router_pkg::*;
#(
   parameter int PAYLOAD_LEN = 8,
   parameter int CNT_W       = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   demux_frame_router_if.slave  s_if,
   input  logic [N_CH-1:0]      chan_en,
   output logic [1:0]           dmx_select,
   output logic                 dmx_data,
   output logic                 dmx_valid,
   output logic                 frame_done,
   output logic                 frame_drop,
   output logic                 busy,
   input  logic [1:0]           cnt_rd_sel,
   output logic [CNT_W-1:0]     cnt_rd_data
);

   // Payload beat counter is wide enough for the full legal PAYLOAD_LEN range
   localparam int BEAT_W = 8;

   state_e            state_q, state_d;
   logic              hdr_msb_q, hdr_msb_d;
   logic [1:0]        ch_q, ch_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [1:0]        sel_q, sel_d;
   logic              data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              drop_q, drop_d;

   logic              xfer_s;
   logic              last_beat_s;
   logic              inc_s;
   logic [HDR_W-1:0]  hdr_s;

   assign s_if.s_ready = ~s_if.hold;
   assign xfer_s       = s_if.s_valid & ~s_if.hold;
   assign hdr_s        = {hdr_msb_q, s_if.s_data};
   assign last_beat_s  = (beat_q == BEAT_W'(PAYLOAD_LEN - 1));

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; nothing advances without a transfer
   always_comb begin
      state_d = state_q;
      if (xfer_s) begin
         case (state_q)
            IDLE:    state_d = HDR;
            HDR:     state_d = chan_en[hdr_s] ? PAYLOAD : DROP;
            PAYLOAD: state_d = last_beat_s ? IDLE : PAYLOAD;
            DROP:    state_d = last_beat_s ? IDLE : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output and datapath next values; pulses and payload default to 0
   always_comb begin
      hdr_msb_d = hdr_msb_q;
      ch_d      = ch_q;
      beat_d    = beat_q;
      sel_d     = sel_q;
      data_d    = 1'b0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      drop_d    = 1'b0;
      inc_s     = 1'b0;
      if (xfer_s) begin
         case (state_q)
            IDLE: begin
               hdr_msb_d = s_if.s_data;
               beat_d    = {BEAT_W{1'b0}};
            end
            HDR: begin
               ch_d   = hdr_s;
               beat_d = {BEAT_W{1'b0}};
               // A disabled channel leaves the select where the last frame put it
               if (chan_en[hdr_s]) begin
                  sel_d = hdr_s;
               end else begin
                  sel_d = sel_q;
               end
            end
            PAYLOAD: begin
               data_d  = s_if.s_data;
               valid_d = 1'b1;
               if (last_beat_s) begin
                  done_d = 1'b1;
                  inc_s  = 1'b1;
                  beat_d = {BEAT_W{1'b0}};
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
            DROP: begin
               if (last_beat_s) begin
                  drop_d = 1'b1;
                  beat_d = {BEAT_W{1'b0}};
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
            default: begin
               beat_d = {BEAT_W{1'b0}};
            end
         endcase
      end else begin
         beat_d = beat_q;
      end
   end

   // Registered outputs and datapath state
   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_msb_q <= 1'b0;
         ch_q      <= 2'b00;
         beat_q    <= {BEAT_W{1'b0}};
         sel_q     <= 2'b00;
         data_q    <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         hdr_msb_q <= hdr_msb_d;
         ch_q      <= ch_d;
         beat_q    <= beat_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         drop_q    <= drop_d;
      end
   end

   assign dmx_select = sel_q;
   assign dmx_data   = data_q;
   assign dmx_valid  = valid_q;
   assign frame_done = done_q;
   assign frame_drop = drop_q;
   assign busy       = (state_q != IDLE);

   // Counter updates on the same edge that raises frame_done
   frame_counter_bank #(
      .CNT_W (CNT_W)
   ) u_cnt_bank (
      .clock     (clock),
      .reset     (reset),
      .inc_i     (inc_s),
      .inc_ch_i  (ch_q),
      .rd_sel_i  (cnt_rd_sel),
      .rd_data_o (cnt_rd_data)
   );

endmodule : demux_frame_router

// File: tb/tb_demux_frame_router.sv
// -----------------------------------------------------------------------------
// tb_demux_frame_router
// Directed self-checking bench for demux_frame_router (PAYLOAD_LEN = 8,
// CNT_W = 8). Inputs change and outputs are sampled 1 time unit after each
// rising edge; expected counter values come from a small per-channel model.
// -----------------------------------------------------------------------------
module tb_demux_frame_router;

   localparam int PL = 8;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    chan_en = 4'hF;
   logic [1:0]    cnt_rd_sel = 2'b00;
   logic [1:0]    dmx_select;
   logic          dmx_data;
   logic          dmx_valid;
   logic          frame_done;
   logic          frame_drop;
   logic          busy;
   logic [CW-1:0] cnt_rd_data;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [7:0]    exp_cnt [4];

   demux_frame_router_if s_if ();

   demux_frame_router #(
      .PAYLOAD_LEN (PL),
      .CNT_W       (CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .s_if        (s_if),
      .chan_en     (chan_en),
      .dmx_select  (dmx_select),
      .dmx_data    (dmx_data),
      .dmx_valid   (dmx_valid),
      .frame_done  (frame_done),
      .frame_drop  (frame_drop),
      .busy        (busy),
      .cnt_rd_sel  (cnt_rd_sel),
      .cnt_rd_data (cnt_rd_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      s_if.s_valid = 1'b1;
      s_if.s_data  = b;
      tick();
   endtask

   task automatic check_counters();
      for (int k = 0; k < 4; k++) begin
         cnt_rd_sel = 2'(k);
         #1;
         check("cnt_all", 32'(cnt_rd_data), 32'(exp_cnt[k]));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
   endtask

   // Full frame: header then payload MSB first, checking every cycle
   task automatic send_frame(input logic [1:0] ch, input logic [7:0] pl,
                             input logic deliver, input logic [1:0] exp_sel);
      cnt_rd_sel = ch;
      send_bit(ch[1]);
      check("hdr_busy", 32'(busy), 32'd1);
      send_bit(ch[0]);
      check("hdr_sel", 32'(dmx_select), 32'(exp_sel));
      check("hdr_valid", 32'(dmx_valid), 32'd0);
      for (int i = PL - 1; i >= 0; i--) begin
         s_if.s_valid = 1'b1;
         s_if.s_data  = pl[i];
         if (i == 0) check("cnt_pre", 32'(cnt_rd_data), 32'(exp_cnt[ch]));
         tick();
         check("pl_valid", 32'(dmx_valid), 32'(deliver));
         check("pl_data", 32'(dmx_data), deliver ? 32'(pl[i]) : 32'd0);
         check("pl_done", 32'(frame_done), (deliver && i == 0) ? 32'd1 : 32'd0);
         check("pl_drop", 32'(frame_drop), (!deliver && i == 0) ? 32'd1 : 32'd0);
         check("pl_sel", 32'(dmx_select), 32'(exp_sel));
      end
      check("end_busy", 32'(busy), 32'd0);
      if (deliver) exp_cnt[ch] = exp_cnt[ch] + 8'd1;
      check("cnt_post", 32'(cnt_rd_data), 32'(exp_cnt[ch]));
   endtask

   initial begin
      logic [7:0] pl;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 1'b0;
      s_if.hold    = 1'b0;
      tick();
      do_reset();

      // Reset state
      check("rst_sel", 32'(dmx_select), 32'd0);
      check("rst_valid", 32'(dmx_valid), 32'd0);
      check("rst_data", 32'(dmx_data), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_drop", 32'(frame_drop), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(s_if.s_ready), 32'd1);
      check_counters();

      // Frame to channel 2, payload 1011_0010
      chan_en = 4'hF;
      send_frame(2'b10, 8'b1011_0010, 1'b1, 2'b10);
      s_if.s_valid = 1'b0;
      tick();
      check("idle_valid", 32'(dmx_valid), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
      check("idle_sel", 32'(dmx_select), 32'd2);

      // Frame to disabled channel 1 is dropped, select holds 2
      chan_en = 4'b1101;
      send_frame(2'b01, 8'hFF, 1'b0, 2'b10);
      check_counters();
      chan_en = 4'hF;

      // Stall mid-payload on channel 3; enables cleared mid-frame must not matter
      pl = 8'hA5;
      cnt_rd_sel = 2'b11;
      send_bit(1'b1);
      send_bit(1'b1);
      check("hold_sel", 32'(dmx_select), 32'd3);
      for (int i = PL - 1; i >= 0; i--) begin
         if (i == 4) begin
            chan_en     = 4'h0;
            s_if.hold   = 1'b1;
            for (int k = 0; k < 3; k++) begin
               s_if.s_valid = 1'b1;
               s_if.s_data  = ~pl[i];
               tick();
               check("hold_ready", 32'(s_if.s_ready), 32'd0);
               check("hold_valid", 32'(dmx_valid), 32'd0);
               check("hold_busy", 32'(busy), 32'd1);
            end
            s_if.hold = 1'b0;
         end
         send_bit(pl[i]);
         check("hold_pl_valid", 32'(dmx_valid), 32'd1);
         check("hold_pl_data", 32'(dmx_data), 32'(pl[i]));
         check("hold_pl_done", 32'(frame_done), (i == 0) ? 32'd1 : 32'd0);
      end
      exp_cnt[3] = exp_cnt[3] + 8'd1;
      check_counters();
      chan_en = 4'hF;

      // Four back-to-back frames, one per channel
      do_reset();
      send_frame(2'b00, 8'h81, 1'b1, 2'b00);
      send_frame(2'b01, 8'h42, 1'b1, 2'b01);
      send_frame(2'b10, 8'h24, 1'b1, 2'b10);
      send_frame(2'b11, 8'h18, 1'b1, 2'b11);
      check_counters();

      // Reset after 5 payload bits discards the partial frame
      cnt_rd_sel = 2'b10;
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b1;
      s_if.s_valid = 1'b1;
      s_if.s_data  = 1'b1;
      tick();
      check("mid_rst_valid", 32'(dmx_valid), 32'd0);
      check("mid_rst_data", 32'(dmx_data), 32'd0);
      check("mid_rst_done", 32'(frame_done), 32'd0);
      check("mid_rst_drop", 32'(frame_drop), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sel", 32'(dmx_select), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
      check_counters();
      send_frame(2'b11, 8'h3C, 1'b1, 2'b11);

      // 256 frames to channel 0: counter wraps back to 0
      for (int n = 0; n < 256; n++) begin
         send_frame(2'b00, 8'(n) ^ 8'h5A, 1'b1, 2'b00);
      end
      cnt_rd_sel = 2'b00;
      #1;
      check("wrap", 32'(cnt_rd_data), 32'd0);
      check_counters();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_demux_frame_router
